// File: rtl/fifo_pkg.sv
// fifo_pkg: shared constants and Gray-code helpers for the async FIFO
// pointer controllers (read side and write side).
//
// The conversion functions work on a zero-extended GRAY_W-bit value so one
// definition serves every pointer width; callers cast in and truncate out.
// Zero upper bits map to zero upper bits in both directions, so truncation
// is exact for any width up to GRAY_W.
package fifo_pkg;

    localparam int GRAY_W        = 32;
    localparam int DEF_ADDR_BITS = 2;
    localparam int DEF_DEPTH     = 1 << DEF_ADDR_BITS;

    // Pointer width including the wrap bit that separates full from empty.
    function automatic int ptr_bits(input int addr_bits);
        return addr_bits + 1;
    endfunction

    function automatic logic [GRAY_W-1:0] bin2gray(input logic [GRAY_W-1:0] b);
        return b ^ (b >> 1);
    endfunction

    // Prefix XOR from the MSB down.
    function automatic logic [GRAY_W-1:0] gray2bin(input logic [GRAY_W-1:0] g);
        logic [GRAY_W-1:0] b;
        b[GRAY_W-1] = g[GRAY_W-1];
        for (int i = GRAY_W - 2; i >= 0; i--) begin
            b[i] = b[i+1] ^ g[i];
        end
        return b;
    endfunction

endpackage

// File: rtl/rd_ptr_ctrl_if.sv
// rd_ptr_ctrl_if: read-side bus between the FIFO consumer and rd_ptr_ctrl.
//
// Handshake: rd_en is a request. It is accepted in a cycle exactly when the
// registered empty flag is low in that cycle; empty is the inverse of ready.
// A request while empty is rejected, leaves the pointer alone and is reported
// by underflow one cycle later. There is no separate data-valid: read data
// comes from the memory at raddr in the accept cycle.
//
// Signals: rd_en, clr_err, wptr_gray_sync (into the controller);
//          raddr, rptr_gray, empty, almost_empty, level, underflow,
//          underflow_sticky (out of the controller).
import fifo_pkg::*;

interface rd_ptr_ctrl_if #(
    parameter int ADDR_BITS = DEF_ADDR_BITS,
    parameter int PTR_BITS  = ptr_bits(ADDR_BITS)
);
    logic                 rd_en;
    logic [PTR_BITS-1:0]  wptr_gray_sync;
    logic                 clr_err;
    logic [ADDR_BITS-1:0] raddr;
    logic [PTR_BITS-1:0]  rptr_gray;
    logic                 empty;
    logic                 almost_empty;
    logic [PTR_BITS-1:0]  level;
    logic                 underflow;
    logic                 underflow_sticky;

    // Consumer side.
    modport master (
        output rd_en, wptr_gray_sync, clr_err,
        input  raddr, rptr_gray, empty, almost_empty, level,
               underflow, underflow_sticky
    );

    // Controller side.
    modport slave (
        input  rd_en, wptr_gray_sync, clr_err,
        output raddr, rptr_gray, empty, almost_empty, level,
               underflow, underflow_sticky
    );
endinterface

// File: rtl/gray_ptr_reg.sv
// gray_ptr_reg: binary + Gray pointer register pair.
//
// Ports: clk, rst (sync, active-high), inc (advance by one),
//        bin/gray (registered values), bin_next/gray_next (values that load
//        on the next edge, exposed so the owner can compute status from them).
// Both registers load together so the Gray copy never lags the binary one.
import fifo_pkg::*;

module gray_ptr_reg #(
    parameter int W = 3
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         inc,
    output logic [W-1:0] bin,
    output logic [W-1:0] gray,
    output logic [W-1:0] bin_next,
    output logic [W-1:0] gray_next
);
    // Natural wrap at 2**W.
    assign bin_next  = bin + W'(inc);
    assign gray_next = W'(bin2gray(GRAY_W'(bin_next)));

    always_ff @(posedge clk) begin
        if (rst) begin
            bin  <= '0;
            gray <= '0;
        end else begin
            bin  <= bin_next;
            gray <= gray_next;
        end
    end
endmodule

// File: rtl/rd_ptr_ctrl.sv
// rd_ptr_ctrl: read-domain pointer and status controller for the async FIFO.
//
// Ports: clk, rst (sync, active-high); bus (rd_ptr_ctrl_if.slave) carrying
//        rd_en, wptr_gray_sync, clr_err in and raddr, rptr_gray, empty,
//        almost_empty, level, underflow, underflow_sticky out.
// All status outputs are registered and computed from the pointer value that
// is being loaded on the same edge, so they change together one cycle after
// the read or write-pointer movement that caused them.
import fifo_pkg::*;

module rd_ptr_ctrl #(
    parameter int ADDR_BITS = DEF_ADDR_BITS,
    parameter int PTR_BITS  = ptr_bits(ADDR_BITS),
    parameter int AE_THRESH = 1
) (
    input logic               clk,
    input logic               rst,
    rd_ptr_ctrl_if.slave      bus
);
    localparam logic [PTR_BITS-1:0] AE_T = PTR_BITS'(AE_THRESH);

    logic                rd_acc;
    logic                rd_rej;
    logic [PTR_BITS-1:0] rbin;
    logic [PTR_BITS-1:0] rgray;
    logic [PTR_BITS-1:0] rbin_next;
    logic [PTR_BITS-1:0] rgray_next;
    logic [PTR_BITS-1:0] wbin;
    logic [PTR_BITS-1:0] level_next;

    logic                empty_q;
    logic                almost_empty_q;
    logic [PTR_BITS-1:0] level_q;
    logic                underflow_q;
    logic                sticky_q;

    // Accept/reject use the registered empty flag, never a combinational one.
    assign rd_acc = bus.rd_en & ~empty_q;
    assign rd_rej = bus.rd_en &  empty_q;

    gray_ptr_reg #(.W(PTR_BITS)) u_rptr (
        .clk       (clk),
        .rst       (rst),
        .inc       (rd_acc),
        .bin       (rbin),
        .gray      (rgray),
        .bin_next  (rbin_next),
        .gray_next (rgray_next)
    );

    assign wbin       = PTR_BITS'(gray2bin(GRAY_W'(bus.wptr_gray_sync)));
    // Modular difference; the wrap bit makes a full FIFO read as 2**ADDR_BITS.
    assign level_next = wbin - rbin_next;

    always_ff @(posedge clk) begin
        if (rst) begin
            empty_q        <= 1'b1;
            almost_empty_q <= 1'b1;
            level_q        <= '0;
            underflow_q    <= 1'b0;
            sticky_q       <= 1'b0;
        end else begin
            empty_q        <= (rgray_next == bus.wptr_gray_sync);
            almost_empty_q <= (level_next <= AE_T);
            level_q        <= level_next;
            underflow_q    <= rd_rej;
            // A new underflow outranks a clear in the same cycle.
            sticky_q       <= rd_rej | (sticky_q & ~bus.clr_err);
        end
    end

    // The wrap bit only matters for full/empty; it never addresses memory.
    logic unused_rbin_msb;
    assign unused_rbin_msb = rbin[PTR_BITS-1];

    assign bus.raddr            = rbin[ADDR_BITS-1:0];
    assign bus.rptr_gray        = rgray;
    assign bus.empty            = empty_q;
    assign bus.almost_empty     = almost_empty_q;
    assign bus.level            = level_q;
    assign bus.underflow        = underflow_q;
    assign bus.underflow_sticky = sticky_q;
endmodule

// File: tb/tb_rd_ptr_ctrl.sv
// tb_rd_ptr_ctrl: bench for rd_ptr_ctrl (ADDR_BITS=2, AE_THRESH=1).
// The reference model counts reads and writes as plain unbounded integers;
// pointers, level and flags are derived from those counts modulo the
// pointer range.
module tb_rd_ptr_ctrl;
    localparam int AB    = 2;
    localparam int PB    = AB + 1;
    localparam int DEPTH = 1 << AB;
    localparam int PMOD  = 2 * DEPTH;
    localparam int AE    = 1;
    localparam int EW    = AB + PB + 1 + 1 + PB + 1 + 1;

    logic clk;
    logic rst;

    rd_ptr_ctrl_if #(.ADDR_BITS(AB)) ifc ();

    rd_ptr_ctrl #(.ADDR_BITS(AB), .AE_THRESH(AE)) dut (
        .clk (clk),
        .rst (rst),
        .bus (ifc.slave)
    );

    // ---------------- clock / reset ----------------
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // ---------------- scoreboard state ----------------
    logic [EW-1:0] exp_q[$];
    int  checks = 0;
    int  errors = 0;
    int  cyc    = 0;
    bit  done   = 0;

    // model state
    int  rd_cnt   = 0;
    int  wr_cnt   = 0;
    bit  m_empty  = 1;
    bit  m_sticky = 0;

    function automatic logic [PB-1:0] to_gray(input int v);
        logic [PB-1:0] b;
        b = PB'(v & (PMOD - 1));
        return b ^ (b >> 1);
    endfunction

    // ---------------- driver ----------------
    task automatic step(input bit r, input bit rd, input int wr, input bit clr);
        int            lvl;
        bit            uf;
        bit            ae;
        logic [EW-1:0] e;
        rst                = r;
        ifc.rd_en          = rd;
        ifc.clr_err        = clr;
        wr_cnt             = wr;
        ifc.wptr_gray_sync = to_gray(wr_cnt);
        if (r) begin
            rd_cnt   = 0;
            m_empty  = 1;
            m_sticky = 0;
            uf       = 0;
            lvl      = 0;
            ae       = 1;
        end else begin
            uf = rd && m_empty;
            if (rd && !m_empty) rd_cnt++;
            lvl      = (wr_cnt - rd_cnt) & (PMOD - 1);
            m_empty  = (lvl == 0);
            ae       = (lvl <= AE);
            m_sticky = uf | (m_sticky & !clr);
        end
        e = {AB'(rd_cnt & (DEPTH - 1)), to_gray(rd_cnt), m_empty, ae,
             PB'(lvl), uf, m_sticky};
        exp_q.push_back(e);
        @(negedge clk);
    endtask

    // ---------------- monitor ----------------
    initial begin
        logic [EW-1:0] got;
        logic [EW-1:0] exp;
        forever begin
            @(posedge clk);
            #1;
            cyc++;
            got = {ifc.raddr, ifc.rptr_gray, ifc.empty, ifc.almost_empty,
                   ifc.level, ifc.underflow, ifc.underflow_sticky};
            if (exp_q.size() > 0) begin
                exp = exp_q.pop_front();
                checks++;
                if (got !== exp) begin
                    errors++;
                    $display("FAIL status cyc=%0d got raddr=%0d gray=%b empty=%b ae=%b level=%0d uf=%b sticky=%b | need raddr=%0d gray=%b empty=%b ae=%b level=%0d uf=%b sticky=%b",
                             cyc, got[EW-1 -: AB], got[EW-AB-1 -: PB], got[PB+3], got[PB+2],
                             got[PB+1:2], got[1], got[0],
                             exp[EW-1 -: AB], exp[EW-AB-1 -: PB], exp[PB+3], exp[PB+2],
                             exp[PB+1:2], exp[1], exp[0]);
                end
            end else if (!done) begin
                checks++;
                errors++;
                $display("FAIL sb_empty cyc=%0d got no expectation need one", cyc);
            end
        end
    end

    // ---------------- stimulus ----------------
    initial begin
        int nxt;
        bit r;
        ifc.rd_en          = 1'b0;
        ifc.clr_err        = 1'b0;
        ifc.wptr_gray_sync = '0;
        rst                = 1'b1;

        // reset held 2 cycles with rd_en high, then a rejected read
        step(1, 1, 0, 0);
        step(1, 1, 0, 0);
        step(0, 1, 0, 0);
        step(0, 0, 0, 0);

        // write pointer to 2, read it down to empty
        step(0, 0, 2, 0);
        step(0, 1, 2, 0);
        step(0, 1, 2, 0);
        step(0, 0, 2, 0);

        // wrap: one write ahead, eight back-to-back reads
        step(1, 0, 0, 0);
        step(0, 0, 1, 0);
        for (int i = 0; i < 8; i++) step(0, 1, i + 2, 0);
        step(0, 0, 9, 0);

        // full view
        step(1, 0, 0, 0);
        step(0, 0, 4, 0);
        step(0, 0, 4, 0);

        // sticky clear and clear-vs-underflow priority
        step(1, 0, 0, 0);
        step(0, 1, 0, 0);
        step(0, 0, 0, 1);
        step(0, 1, 0, 0);
        step(0, 1, 0, 1);
        step(0, 0, 0, 0);

        // reset mid-stream at level 3, then level recomputed from rbin=0
        step(1, 0, 0, 0);
        step(0, 0, 3, 0);
        step(0, 0, 3, 0);
        step(1, 0, 3, 0);
        step(0, 0, 3, 0);

        // randomized traffic
        for (int i = 0; i < 600; i++) begin
            r   = ($urandom_range(0, 63) == 0);
            nxt = wr_cnt + $urandom_range(0, 2);
            if (nxt > rd_cnt + DEPTH) nxt = rd_cnt + DEPTH;
            step(r, $urandom_range(0, 3) != 0, nxt, $urandom_range(0, 7) == 0);
        end

        done = 1;
        @(posedge clk);
        #2;
        if (exp_q.size() != 0) begin
            checks++;
            errors++;
            $display("FAIL sb_drain got %0d left need 0", exp_q.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
